// File: rtl/fp32_div_arbiter.sv
// Round-robin arbiter that time-shares one iterative fp32 divider among NUM_REQ requesters,
// with a post-reset drain period and a watchdog that answers with a flagged quiet NaN.
module fp32_div_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [31:0]            rsp_data,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   div_start,
  output logic [31:0]            div_a,
  output logic [31:0]            div_b,
  input  logic                   div_done,
  input  logic [31:0]            div_answer
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  localparam logic [31:0]   QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_DRAIN,
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state_reg;
  logic [TW-1:0] timer_reg;
  logic [IW-1:0] rr_ptr_reg;
  logic [IW-1:0] gnt_reg;

  logic [31:0]        a_arr [NUM_REQ];
  logic [31:0]        b_arr [NUM_REQ];
  logic [NUM_REQ-1:0] gnt_onehot;
  logic [IW-1:0]      grant_idx;
  logic               grant_found;
  logic [IW-1:0]      cand;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign a_arr[gi]      = req_a[32*gi +: 32];
    assign b_arr[gi]      = req_b[32*gi +: 32];
    assign gnt_onehot[gi] = (gnt_reg == IW'(gi));
    assign req_ready[gi]  = (state_reg == S_IDLE) && grant_found && (grant_idx == IW'(gi));
  end

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (int'(rr_ptr_reg) + k >= NUM_REQ)
        cand = IW'(int'(rr_ptr_reg) + k - NUM_REQ);
      else
        cand = IW'(int'(rr_ptr_reg) + k);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= S_DRAIN;
      timer_reg  <= '0;
      rr_ptr_reg <= '0;
      gnt_reg    <= '0;
      div_start  <= 1'b0;
      div_a      <= '0;
      div_b      <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      div_start <= 1'b0;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      case (state_reg)
        S_DRAIN: begin
          busy <= 1'b1;
          if (timer_reg == TMAX) begin
            state_reg <= S_IDLE;
            timer_reg <= '0;
            busy      <= 1'b0;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        S_IDLE: begin
          busy <= 1'b0;
          if (grant_found) begin
            gnt_reg   <= grant_idx;
            div_a     <= a_arr[grant_idx];
            div_b     <= b_arr[grant_idx];
            div_start <= 1'b1;
            busy      <= 1'b1;
            state_reg <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer_reg <= '0;
          state_reg <= S_WAIT;
        end
        S_WAIT: begin
          // The previous operation's done level is still visible while timer is 0.
          if (timer_reg != '0 && div_done) begin
            rsp_data  <= div_answer;
            rsp_valid <= gnt_onehot;
            state_reg <= S_RESP;
          end else if (timer_reg == TMAX) begin
            rsp_data  <= QNAN;
            rsp_err   <= 1'b1;
            rsp_valid <= gnt_onehot;
            state_reg <= S_RESP;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        S_RESP: begin
          rr_ptr_reg <= (gnt_reg == IW'(NUM_REQ - 1)) ? '0 : gnt_reg + 1'b1;
          busy       <= 1'b0;
          state_reg  <= S_IDLE;
        end
        default: state_reg <= S_DRAIN;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_div_arbiter.sv
// Randomized scoreboard bench for fp32_div_arbiter with a behavioural 12-cycle divider model.
module tb_fp32_div_arbiter;
  localparam int N = 4;
  localparam int TIMEOUT = 64;
  localparam int LAT = 12;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [32*N-1:0] req_a = '0;
  logic [32*N-1:0] req_b = '0;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [31:0]     rsp_data, div_a, div_b;
  logic            rsp_err, busy, div_start;
  logic            div_done = 1'b0;
  logic [31:0]     div_answer = '0;

  fp32_div_arbiter #(.NUM_REQ(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_answer(div_answer)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic        err;
    int          acc_cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] op_q[N][$];
  int          grant_hist[$];
  logic [31:0] rsp_by_req[N];
  int errors = 0, checks = 0, cyc = 0;
  int model_ptr = 0, accept_cnt = 0, last_acc_cyc = 0, reset_cyc = 0;
  bit hang = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Round-to-nearest-even fp32 division for normal operands.
  function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] num, den, q, r, m;
    int e, sh;
    logic guard, sticky;
    num = {40'd0, 1'b1, a[22:0]} << 26;
    den = {40'd0, 1'b1, b[22:0]};
    q = num / den;
    r = num % den;
    e = int'(a[30:23]) - int'(b[30:23]) + 127;
    if (q >= (64'd1 << 26)) sh = 3;
    else begin
      sh = 2;
      e = e - 1;
    end
    guard  = q[sh-1];
    sticky = (r != 0) || ((q & ((64'd1 << (sh - 1)) - 1)) != 0);
    m = q >> sh;
    if (guard && (sticky || m[0])) m = m + 1;
    if (m == (64'd1 << 24)) begin
      m = m >> 1;
      e = e + 1;
    end
    return {a[31] ^ b[31], e[7:0], m[22:0]};
  endfunction

  function automatic logic [63:0] rand_op();
    logic [31:0] a, b;
    a = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
    b = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
    return {a, b};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Divider model: no reset, done is sticky and drops one cycle after the start is taken.
  int          dcnt = 0;
  logic [31:0] cap_a = '0, cap_b = '0;
  bit          clr = 1'b0;
  always @(posedge clk) begin
    clr <= 1'b0;
    if (clr) div_done <= 1'b0;
    if (div_start) begin
      cap_a <= div_a;
      cap_b <= div_b;
      dcnt  <= LAT;
      clr   <= 1'b1;
    end else if (dcnt > 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1 && !hang) begin
        div_done   <= 1'b1;
        div_answer <= fdiv(cap_a, cap_b);
      end
    end
  end

  // Requester driver: presents each queue head, predicts the grant, pushes the expected response.
  initial begin
    logic [N-1:0] acc;
    logic [63:0]  op;
    int g, eg;
    forever begin
      @(negedge clk);
      acc = '0;
      if (rst_n) begin
        check("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
        check("ready_subset", 32'(req_ready & ~req_valid), 32'd0);
        if (req_ready != '0) begin
          g = -1;
          eg = -1;
          for (int i = 0; i < N; i++) if (req_ready[i] && g < 0) g = i;
          for (int k = 0; k < N; k++)
            if (eg < 0 && req_valid[(model_ptr + k) % N]) eg = (model_ptr + k) % N;
          check("grant_idx", 32'(g), 32'(eg));
          exp_q.push_back('{eg, hang ? QNAN : fdiv(req_a[32*eg +: 32], req_b[32*eg +: 32]),
                            hang, cyc});
          grant_hist.push_back(g);
          model_ptr = (eg + 1) % N;
          accept_cnt++;
          last_acc_cyc = cyc;
          acc = req_ready;
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && op_q[i].size() > 0) void'(op_q[i].pop_front());
        if (op_q[i].size() > 0) begin
          op = op_q[i][0];
          req_valid[i] = 1'b1;
          req_a[32*i +: 32] = op[63:32];
          req_b[32*i +: 32] = op[31:0];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid=%b with nothing outstanding", rsp_valid);
        end else begin
          e = exp_q.pop_front();
          check("rsp_valid", 32'(rsp_valid), 32'(1) << e.idx);
          check("rsp_data", rsp_data, e.data);
          check("rsp_err", 32'(rsp_err), 32'(e.err));
          check("latency", 32'(cyc - e.acc_cyc), e.err ? 32'(TIMEOUT + 2) : 32'(LAT + 3));
          rsp_by_req[e.idx] = rsp_data;
          $display("rsp req=%0d data=%h err=%0d latency=%0d", e.idx, rsp_data, rsp_err,
                   cyc - e.acc_cyc);
        end
      end else begin
        check("idle_rsp_err", 32'(rsp_err), 32'd0);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_data"}, rsp_data, 32'd0);
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_div_start"}, 32'(div_start), 32'd0);
    check({tag, "_div_a"}, div_a, 32'd0);
    check({tag, "_div_b"}, div_b, 32'd0);
  endtask

  task automatic wait_idle(input int budget);
    int pending;
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      pending = exp_q.size();
      for (int i = 0; i < N; i++) pending += op_q[i].size();
      if (pending == 0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL wait_idle: got work still pending after %0d cycles expected none", budget);
    end
    @(negedge clk);
  endtask

  initial begin
    int start_cnt;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    reset_cyc = cyc;

    // Single request held through the drain period.
    op_q[0].push_back({32'h40C0_0000, 32'h4000_0000});
    repeat (10) @(negedge clk);
    check("drain_busy", 32'(busy), 32'd1);
    check("drain_ready", 32'(req_ready), 32'd0);
    wait_idle(400);
    check("drain_len", 32'(last_acc_cyc - reset_cyc), 32'(TIMEOUT));
    check("single_q", rsp_by_req[0], 32'h4040_0000);

    // Contention: all four at once.
    op_q[0].push_back({32'h40C0_0000, 32'h4000_0000});
    op_q[1].push_back({32'h3F80_0000, 32'h4080_0000});
    op_q[2].push_back(rand_op());
    op_q[3].push_back(rand_op());
    wait_idle(400);
    check("quarter_q", rsp_by_req[1], 32'h3E80_0000);

    // Fairness: two requesters continuously valid.
    grant_hist.delete();
    for (int k = 0; k < 5; k++) begin
      op_q[0].push_back(rand_op());
      op_q[2].push_back(rand_op());
    end
    wait_idle(600);
    check("fair_count", 32'(grant_hist.size()), 32'd10);
    for (int k = 1; k < grant_hist.size(); k++)
      check("fair_alternate", 32'(grant_hist[k] != grant_hist[k-1]), 32'd1);

    // Randomized traffic.
    for (int r = 0; r < 40; r++) begin
      op_q[$urandom_range(0, N - 1)].push_back(rand_op());
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 20)) @(negedge clk);
    end
    wait_idle(2000);

    // Watchdog: divider never answers, then a normal request.
    hang = 1'b1;
    op_q[3].push_back(rand_op());
    wait_idle(400);
    hang = 1'b0;
    op_q[1].push_back(rand_op());
    wait_idle(400);

    // Reset in the middle of WAIT.
    start_cnt = accept_cnt;
    op_q[2].push_back(rand_op());
    for (int c = 0; c < 200 && accept_cnt == start_cnt; c++) @(negedge clk);
    check("mid_accept_seen", 32'(accept_cnt - start_cnt), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("mid_reset");
    rst_n = 1'b1;
    reset_cyc = cyc;
    exp_q.delete();
    model_ptr = 0;
    rsp_by_req[0] = '0;
    op_q[0].push_back({32'h40C0_0000, 32'h4000_0000});
    wait_idle(400);
    check("mid_drain_len", 32'(last_acc_cyc - reset_cyc), 32'(TIMEOUT));
    check("mid_after_q", rsp_by_req[0], 32'h4040_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
